// File: rtl/dmem_access_pkg.sv
// pipes: shared types, constants and helpers for the data-memory access path.
// No ports; imported by dmem_access and load_extend.
package pipes;
    localparam int D_XLEN   = 64;
    localparam int D_ADDR_W = 64;
    localparam int D_STRB_W = D_XLEN / 8;

    typedef logic [1:0] msize_t;

    localparam msize_t MSIZE_B = 2'd0;
    localparam msize_t MSIZE_H = 2'd1;
    localparam msize_t MSIZE_W = 2'd2;
    localparam msize_t MSIZE_D = 2'd3;

    typedef enum logic [1:0] {IDLE, REQ, DONE, DRAIN} dmem_state_t;

    typedef struct packed {
        logic                valid;
        logic [D_ADDR_W-1:0] addr;
        logic                write;
        msize_t              size;
        logic [D_STRB_W-1:0] strobe;
        logic [D_XLEN-1:0]   data;
    } dbus_req_t;

    typedef struct packed {
        logic              data_ok;
        logic [D_XLEN-1:0] data;
    } dbus_resp_t;

    // Byte-lane mask of an access before it is shifted to its offset.
    function automatic logic [D_STRB_W-1:0] size_mask(msize_t s);
        return s == MSIZE_B ? 8'h01 : s == MSIZE_H ? 8'h03 : s == MSIZE_W ? 8'h0F : 8'hFF;
    endfunction

    function automatic logic is_misaligned(msize_t s, logic [2:0] off);
        return s == MSIZE_H ? off[0] : s == MSIZE_W ? |off[1:0] : s == MSIZE_D ? |off : 1'b0;
    endfunction
endpackage

// File: rtl/load_extend.sv
// load_extend: shifts a raw bus doubleword down to its byte offset and sign/zero-extends it.
// Ports: data (raw doubleword), off (byte offset), size (access size), zext (zero-extend),
//        result (aligned, extended value). Purely combinational.
module load_extend
    import pipes::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      off,
    input  msize_t          size,
    input  logic            zext,
    output logic [XLEN-1:0] result
);
    logic [XLEN-1:0] raw;
    logic            sign;

    assign raw  = data >> {off, 3'b000};
    assign sign = ~zext & (size == MSIZE_B ? raw[7] : size == MSIZE_H ? raw[15] : raw[31]);
    assign result = size == MSIZE_D ? raw
                  : size == MSIZE_W ? {{(XLEN-32){sign}}, raw[31:0]}
                  : size == MSIZE_H ? {{(XLEN-16){sign}}, raw[15:0]}
                  :                   {{(XLEN-8){sign}}, raw[7:0]};
endmodule

// File: rtl/dmem_access.sv
// dmem_access: turns an execute-stage load/store into one outstanding data-bus transaction.
// Ports: clk/resetn; ex_* (access from execute), flush (kill current instruction);
//        dreq_* (bus request), dresp_* (bus response); mem_rdata (extended load data),
//        misalign (access not issued), stall (hold execute and upstream).
module dmem_access
    import pipes::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ex_valid,
    input  logic                ex_memread,
    input  logic                ex_memwrite,
    input  logic [ADDR_W-1:0]   ex_addr,
    input  logic [XLEN-1:0]     ex_wdata,
    input  msize_t              ex_msize,
    input  logic                ex_unsigned,
    input  logic                flush,
    output logic                dreq_valid,
    output logic [ADDR_W-1:0]   dreq_addr,
    output logic                dreq_write,
    output msize_t              dreq_size,
    output logic [XLEN/8-1:0]   dreq_strobe,
    output logic [XLEN-1:0]     dreq_data,
    input  logic                dresp_data_ok,
    input  logic [XLEN-1:0]     dresp_data,
    output logic [XLEN-1:0]     mem_rdata,
    output logic                misalign,
    output logic                stall
);
    dmem_state_t       state, state_n;
    dbus_req_t         req_q;
    logic              req_zext;
    logic [XLEN-1:0]   rdata_q, ext;
    logic [XLEN/8-1:0] strobe;
    logic [2:0]        off;
    logic              start, issue, latch;

    assign off      = ex_addr[2:0];
    assign misalign = is_misaligned(ex_msize, off);
    assign start    = ex_valid & (ex_memread | ex_memwrite) & ~misalign & ~flush;
    assign strobe   = ex_memwrite ? size_mask(ex_msize) << off : '0;

    always_comb begin
        state_n = state;
        stall   = 1'b0;
        issue   = 1'b0;
        latch   = 1'b0;
        unique case (state)
            IDLE: begin
                stall = start;
                issue = start;
                if (start) state_n = REQ;
            end
            REQ: begin
                stall = 1'b1;
                // data_ok beats flush; the pipeline discards the flushed result itself.
                if (dresp_data_ok) begin
                    state_n = DONE;
                    latch   = 1'b1;
                end else if (flush) begin
                    state_n = DRAIN;
                end
            end
            DONE: state_n = IDLE;
            DRAIN: begin
                // The bus still owes a response; a new access waits for IDLE.
                stall = start;
                if (dresp_data_ok) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    // dreq_valid is kept as a register so the bus sees a glitch-free request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_q    <= '0;
            req_zext <= 1'b0;
        end else if (issue) begin
            req_q    <= '{valid: 1'b1, addr: ex_addr, write: ex_memwrite, size: ex_msize,
                          strobe: strobe, data: ex_wdata << {off, 3'b000}};
            req_zext <= ex_unsigned;
        end else if ((state == REQ || state == DRAIN) && dresp_data_ok) begin
            req_q.valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                    rdata_q <= '0;
        else if (latch && !req_q.write) rdata_q <= ext;
    end

    load_extend #(.XLEN(XLEN)) u_ext (
        .data   (dresp_data),
        .off    (req_q.addr[2:0]),
        .size   (req_q.size),
        .zext   (req_zext),
        .result (ext)
    );

    assign dreq_valid  = req_q.valid;
    assign dreq_addr   = req_q.addr;
    assign dreq_write  = req_q.write;
    assign dreq_size   = req_q.size;
    assign dreq_strobe = req_q.strobe;
    assign dreq_data   = req_q.data;
    assign mem_rdata   = rdata_q;
endmodule

// File: tb/tb_dmem_access.sv
// tb_dmem_access: directed and randomized checks of dmem_access against a behavioural model.
module tb_dmem_access;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ex_valid = 1'b0, ex_memread = 1'b0, ex_memwrite = 1'b0;
    logic [63:0] ex_addr = '0, ex_wdata = '0;
    logic [1:0]  ex_msize = '0;
    logic        ex_unsigned = 1'b0, flush = 1'b0;
    logic        dreq_valid, dreq_write;
    logic [63:0] dreq_addr, dreq_data;
    logic [1:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic        dresp_data_ok = 1'b0;
    logic [63:0] dresp_data = '0;
    logic [63:0] mem_rdata;
    logic        misalign, stall;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_rd = '0;

    dmem_access dut (
        .clk(clk), .resetn(resetn),
        .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_msize(ex_msize),
        .ex_unsigned(ex_unsigned), .flush(flush),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_write(dreq_write),
        .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .mem_rdata(mem_rdata), .misalign(misalign), .stall(stall)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] m_strobe(int sz, int off);
        int nb = 1 << sz;
        return 8'(((1 << nb) - 1) << off);
    endfunction

    function automatic logic [63:0] m_load(logic [63:0] raw, int off, int sz, bit uns);
        int          nb = 1 << sz;
        logic [63:0] v = raw >> (off * 8);
        logic [63:0] mask;
        if (nb == 8) return v;
        mask = (64'd1 << (nb * 8)) - 64'd1;
        v = v & mask;
        if (!uns && v[nb*8-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // One complete access from IDLE; lat = REQ cycles including the data_ok cycle.
    task automatic access(input bit wr, input logic [63:0] addr, input logic [63:0] wd,
                          input int sz, input bit uns, input logic [63:0] rd, input int lat);
        int st = 0;
        int off = int'(addr[2:0]);
        @(negedge clk);
        ex_valid = 1'b1; ex_memread = !wr; ex_memwrite = wr; ex_addr = addr;
        ex_wdata = wd; ex_msize = 2'(sz); ex_unsigned = uns;
        #1;
        chk("misalign_ok", 64'(misalign), 64'd0);
        chk("idle_valid", 64'(dreq_valid), 64'd0);
        if (stall) st++;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            if (i == lat - 1) begin
                dresp_data_ok = 1'b1;
                dresp_data = rd;
            end
            #1;
            if (stall) st++;
            chk("req_valid", 64'(dreq_valid), 64'd1);
            chk("req_addr", dreq_addr, addr);
            chk("req_write", 64'(dreq_write), 64'(wr));
            chk("req_size", 64'(dreq_size), 64'(sz));
            chk("req_strobe", 64'(dreq_strobe), wr ? 64'(m_strobe(sz, off)) : 64'd0);
            if (wr) chk("req_data", dreq_data, wd << (off * 8));
        end
        @(negedge clk);
        dresp_data_ok = 1'b0;
        dresp_data = {$urandom, $urandom};
        if (!wr) exp_rd = m_load(rd, off, sz, uns);
        #1;
        chk("done_stall", 64'(stall), 64'd0);
        chk("done_valid", 64'(dreq_valid), 64'd0);
        chk("done_rdata", mem_rdata, exp_rd);
        chk("stall_cycles", 64'(st), 64'(lat + 1));
        ex_valid = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_valid", 64'(dreq_valid), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_rdata", mem_rdata, 64'd0);
        chk("rst_addr", dreq_addr, 64'd0);
        chk("rst_strobe", 64'(dreq_strobe), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        access(1'b0, 64'h8000_0010, 64'd0, 3, 1'b0, 64'h1122_3344_5566_7788, 1);
        chk("ld_value", mem_rdata, 64'h1122_3344_5566_7788);
        access(1'b0, 64'h8000_0003, 64'd0, 0, 1'b0, 64'h0000_0000_8000_0000, 2);
        chk("lb_value", mem_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        access(1'b0, 64'h8000_0003, 64'd0, 0, 1'b1, 64'h0000_0000_8000_0000, 1);
        chk("lbu_value", mem_rdata, 64'h0000_0000_0000_0080);
        access(1'b1, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 1, 1'b0, 64'd0, 2);
        chk("sh_keeps_rdata", mem_rdata, 64'h0000_0000_0000_0080);

        // misaligned store: never issued, never stalls
        @(negedge clk);
        ex_valid = 1'b1; ex_memread = 1'b0; ex_memwrite = 1'b1;
        ex_addr = 64'h8000_0002; ex_msize = 2'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sw_misalign", 64'(misalign), 64'd1);
            chk("sw_stall", 64'(stall), 64'd0);
            chk("sw_valid", 64'(dreq_valid), 64'd0);
            @(negedge clk);
        end
        ex_valid = 1'b0;

        // flush in REQ -> DRAIN; next load held off until the old response arrives
        @(negedge clk);
        ex_valid = 1'b1; ex_memread = 1'b1; ex_memwrite = 1'b0;
        ex_addr = 64'h8000_0020; ex_msize = 2'd2; ex_unsigned = 1'b0;
        #1 chk("fl_idle_stall", 64'(stall), 64'd1);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("fl_req_valid", 64'(dreq_valid), 64'd1);
        chk("fl_req_stall", 64'(stall), 64'd1);
        @(negedge clk);
        flush = 1'b0; ex_valid = 1'b0;
        #1;
        chk("dr_stall_drop", 64'(stall), 64'd0);
        chk("dr_valid", 64'(dreq_valid), 64'd1);
        ex_valid = 1'b1; ex_addr = 64'h8000_0040; ex_msize = 2'd3;
        #1;
        chk("dr_stall_held", 64'(stall), 64'd1);
        chk("dr_addr", dreq_addr, 64'h8000_0020);
        @(negedge clk);
        #1;
        chk("dr_valid2", 64'(dreq_valid), 64'd1);
        chk("dr_addr2", dreq_addr, 64'h8000_0020);
        @(negedge clk);
        dresp_data_ok = 1'b1; dresp_data = 64'hDEAD_BEEF_DEAD_BEEF;
        #1 chk("dr_valid3", 64'(dreq_valid), 64'd1);
        @(negedge clk);
        dresp_data_ok = 1'b0;
        #1;
        chk("dr_idle_valid", 64'(dreq_valid), 64'd0);
        chk("dr_idle_stall", 64'(stall), 64'd1);
        chk("dr_rdata_kept", mem_rdata, exp_rd);
        @(negedge clk);
        dresp_data_ok = 1'b1; dresp_data = 64'h0123_4567_89AB_CDEF;
        #1;
        chk("nx_valid", 64'(dreq_valid), 64'd1);
        chk("nx_addr", dreq_addr, 64'h8000_0040);
        @(negedge clk);
        dresp_data_ok = 1'b0; exp_rd = 64'h0123_4567_89AB_CDEF;
        #1;
        chk("nx_rdata", mem_rdata, exp_rd);
        chk("nx_stall", 64'(stall), 64'd0);
        ex_valid = 1'b0;

        // asynchronous reset in the middle of REQ
        @(negedge clk);
        ex_valid = 1'b1; ex_memread = 1'b1; ex_memwrite = 1'b0;
        ex_addr = 64'h8000_0100; ex_msize = 2'd3;
        @(negedge clk);
        #1 chk("ar_req_valid", 64'(dreq_valid), 64'd1);
        #2;
        ex_valid = 1'b0; resetn = 1'b0; exp_rd = '0;
        #1;
        chk("ar_valid", 64'(dreq_valid), 64'd0);
        chk("ar_stall", 64'(stall), 64'd0);
        chk("ar_rdata", mem_rdata, 64'd0);
        chk("ar_addr", dreq_addr, 64'd0);
        ex_addr = 64'h8000_0101; ex_msize = 2'd1;
        #1 chk("ar_misalign", 64'(misalign), 64'd1);
        ex_addr = 64'h8000_0100; ex_valid = 1'b1;
        #1 chk("ar_comb_stall", 64'(stall), 64'd1);
        ex_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'hFFFF_0000_FFFF_0000;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        #1;
        chk("late_valid", 64'(dreq_valid), 64'd0);
        chk("late_rdata", mem_rdata, 64'd0);
        access(1'b0, 64'h8000_0108, 64'd0, 3, 1'b0, 64'hCAFE_F00D_1234_5678, 1);

        for (int n = 0; n < 40; n++) begin
            int          sz = $urandom_range(0, 3);
            int          off = $urandom_range(0, 7) & ~((1 << sz) - 1);
            logic [63:0] a = 64'h8000_0000 + 64'($urandom_range(0, 255) * 8 + off);
            access(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, sz,
                   1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom_range(1, 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_access.md
Name: dmem_access

Overview:
- Data-memory access unit between the execute stage and the memory stage of the pipelined RV64 core.
- Turns a load/store from execute into a single-outstanding data-bus transaction with a valid/data_ok handshake, and generates byte strobes and lane-shifted write data.
- Returns the loaded doubleword, aligned and sign/zero-extended, which the memory stage selects as its register write-back value.
- Asserts a pipeline stall while the transaction is outstanding.

Parameters:
- XLEN, 64, data word width in bits; the byte-strobe width is XLEN/8.
- ADDR_W, 64, data-bus address width in bits.

Ports:
- clk  in  1  pipeline clock.
- resetn  in  1  asynchronous active-low reset.
- ex_valid  in  1  execute-stage instruction is valid.
- ex_memread  in  1  the instruction is a load.
- ex_memwrite  in  1  the instruction is a store.
- ex_addr  in  ADDR_W  effective address (the execute result).
- ex_wdata  in  XLEN  store data, right-aligned.
- ex_msize  in  2  access size: 0=byte, 1=half, 2=word, 3=double.
- ex_unsigned  in  1  zero-extend the load result (LBU/LHU/LWU).
- flush  in  1  kill the current instruction (branch or exception).
- dreq_valid  out  1  bus request valid.
- dreq_addr  out  ADDR_W  request address (the full ex_addr).
- dreq_write  out  1  1 = store.
- dreq_size  out  2  equals ex_msize.
- dreq_strobe  out  XLEN/8  byte-lane enables.
- dreq_data  out  XLEN  lane-shifted store data.
- dresp_data_ok  in  1  bus completion pulse.
- dresp_data  in  XLEN  raw read doubleword.
- mem_rdata  out  XLEN  extended load data to the memory stage.
- misalign  out  1  the access is misaligned; no bus request is issued.
- stall  out  1  hold the pipeline registers at and upstream of execute.

Behaviour:
- The access condition is start = ex_valid & (ex_memread|ex_memwrite) & !misalign & !flush.
- misalign is combinational: addr[0]!=0 for half, addr[1:0]!=0 for word, addr[2:0]!=0 for double.
- off = ex_addr[2:0].
  - Strobe = (1<<2^msize)-1, shifted left by off.
  - dreq_data = ex_wdata shifted left by off*8.
  - For loads, dreq_strobe is 0.
- FSM states: IDLE, REQ, DONE, DRAIN.
- IDLE:
  - stall = start.
  - If start, go to REQ. The request fields are registered from the ex_* inputs on this edge.
- REQ:
  - dreq_valid=1, stall=1.
  - All dreq_* outputs stay constant until the dresp_data_ok cycle, inclusive.
  - On data_ok: latch the extended read data into the mem_rdata register (loads only) and go to DONE.
  - On flush without data_ok: go to DRAIN, with dreq_valid still 1.
  - data_ok and flush in the same cycle: data_ok wins and the FSM goes to DONE. The flushed instruction is then discarded by the pipeline, not by this block.
- DONE:
  - stall=0, dreq_valid=0.
  - The pipeline advances on this edge, so the memory stage samples mem_rdata this cycle.
  - Next state is IDLE. A new access can begin in the following cycle, not in DONE; this gives one bubble per access.
- DRAIN:
  - dreq_valid=1 and stall=0, so the pipeline proceeds.
  - On data_ok, go to IDLE and discard the data.
  - While in DRAIN, a new start is held off: stall = start until IDLE is reached.
- Load extension:
  - The raw value is dresp_data >> off*8.
  - The raw value is then truncated to the access size and sign-extended, or zero-extended if ex_unsigned or size=3.
- The mem_rdata register holds its value until the next load completes.
- Reset (asynchronous, any state including mid-REQ):
  - State goes to IDLE; dreq_valid, stall and the mem_rdata register go to 0.
  - All registered request fields go to 0.
  - The combinational misalign output and the combinational IDLE stall=start term follow their current inputs, even while resetn is low.
  - A response arriving after reset is ignored because the FSM is in IDLE.
- Latency: a request issued in the cycle after start with data_ok in that same cycle gives a best case of 3 cycles per access (IDLE, REQ, DONE).

Decomposition:
- Shared package pipes:
  - typedef msize_t (2-bit), enum dmem_state_t, MSIZE_B/H/W/D constants.
  - A dbus_req_t struct (valid, addr, write, size, strobe, data) and a dbus_resp_t struct (data_ok, data).
- Sub-module load_extend: purely combinational offset shift plus sign/zero extension. It is reusable by a future cache.

Test Plan:
- LD at addr 0x80000010, bus returns 0x1122334455667788 with data_ok one cycle after the request -> stall high for 2 cycles, mem_rdata = 0x1122334455667788 in DONE.
- LB at 0x80000003, dresp_data = 0x00000000_80000000 -> byte 0x80, mem_rdata = 0xFFFFFFFFFFFFFF80. The same access as LBU gives 0x80.
- SH at 0x80000006 with wdata 0xABCD -> dreq_strobe = 0xC0, dreq_data[63:48] = 0xABCD, dreq_write=1.
- SW at 0x80000002 -> misalign=1, dreq_valid never asserted, stall=0.
- LW issued, then flush in REQ with data_ok 3 cycles later -> FSM goes to DRAIN, stall drops immediately, the next load's request is not issued until after data_ok, mem_rdata is unchanged.
- resetn pulled low while in REQ -> dreq_valid and stall go to 0 asynchronously, a late data_ok is ignored, and the next LD completes normally.
